// File: rtl/ccff_loader_if.sv
// Byte-stream side of the configuration-chain loader: host config bytes in,
// readback bytes out. The loader is the slave; the host/bring-up block is the master.
interface ccff_loader_if;
  logic       cfg_start;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_data;
  logic [7:0] rb_data;
  logic       rb_valid;

  modport master (output cfg_start, cfg_valid, cfg_data, input cfg_ready, rb_data, rb_valid);
  modport slave  (input cfg_start, cfg_valid, cfg_data, output cfg_ready, rb_data, rb_valid);
endinterface

// File: rtl/ccff_loader.sv
// Serializes config bytes LSB-first onto the fabric's ccff chain and packs the
// bits leaving the chain tail back into readback bytes.
module ccff_loader #(
  parameter int CHAIN_LEN = 12,
  parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic           prog_clk,
  input  logic           pReset,
  ccff_loader_if.slave   cfg,
  output logic           ccff_head,
  output logic           ccff_shift_en,
  input  logic           ccff_tail,
  output logic           busy,
  output logic           done
);

  typedef enum logic [1:0] {IDLE, WAIT_BYTE, SHIFT, DONE} state_t;

  state_t           state;
  logic [7:0]       sreg;
  logic [3:0]       nbits;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] rb_rem;
  logic [7:0]       rb;
  logic [2:0]       rbidx;
  logic [7:0]       rb_next;

  always_comb begin
    rb_next        = rb;
    rb_next[rbidx] = ccff_tail;
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state         <= IDLE;
      sreg          <= '0;
      nbits         <= '0;
      remaining     <= '0;
      rb_rem        <= '0;
      rb            <= '0;
      rbidx         <= '0;
      ccff_head     <= 1'b0;
      ccff_shift_en <= 1'b0;
      cfg.cfg_ready <= 1'b0;
      cfg.rb_data   <= '0;
      cfg.rb_valid  <= 1'b0;
      done          <= 1'b0;
      busy          <= 1'b0;
    end else begin
      cfg.rb_valid  <= 1'b0;
      done          <= 1'b0;
      ccff_shift_en <= 1'b0;
      // busy lags the state by one cycle so it drops only after the done pulse
      busy          <= !(state == IDLE && !cfg.cfg_start);

      // Tail is sampled on the same edge the chain advances
      if (ccff_shift_en) begin
        rb_rem <= rb_rem - CNT_W'(1);
        if (rbidx == 3'd7 || rb_rem == CNT_W'(1)) begin
          cfg.rb_data  <= rb_next;
          cfg.rb_valid <= 1'b1;
          rb           <= '0;
          rbidx        <= '0;
        end else begin
          rb    <= rb_next;
          rbidx <= rbidx + 3'd1;
        end
      end

      case (state)
        IDLE: begin
          if (cfg.cfg_start) begin
            remaining     <= CNT_W'(CHAIN_LEN);
            rb_rem        <= CNT_W'(CHAIN_LEN);
            cfg.cfg_ready <= 1'b1;
            state         <= WAIT_BYTE;
          end
        end
        WAIT_BYTE: begin
          if (cfg.cfg_valid) begin
            sreg          <= cfg.cfg_data;
            nbits         <= (32'(remaining) > 32'd8) ? 4'd8 : 4'(remaining);
            cfg.cfg_ready <= 1'b0;
            state         <= SHIFT;
          end
        end
        SHIFT: begin
          ccff_head     <= sreg[0];
          ccff_shift_en <= (nbits != 4'd0);
          sreg          <= sreg >> 1;
          // nbits==0 only after the final bit: lets its enable cycle finish before DONE
          if (nbits == 4'd0) begin
            state <= DONE;
          end else begin
            nbits     <= nbits - 4'd1;
            remaining <= remaining - CNT_W'(1);
            if (nbits == 4'd1 && remaining != CNT_W'(1)) begin
              cfg.cfg_ready <= 1'b1;
              state         <= WAIT_BYTE;
            end
          end
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_loader.sv
// Bench for ccff_loader: a behavioural 12-bit chain on head/tail, a bit-stream
// reference for head and readback, and cycle stamps for the timing relations.
module tb_ccff_loader;
  localparam int CL = 12;
  localparam int NB = (CL + 7) / 8;

  logic prog_clk = 1'b0;
  logic pReset   = 1'b1;
  logic ccff_head, ccff_shift_en, ccff_tail, busy, done;

  ccff_loader_if bus();

  ccff_loader #(.CHAIN_LEN(CL)) dut (
    .prog_clk      (prog_clk),
    .pReset        (pReset),
    .cfg           (bus),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .ccff_tail     (ccff_tail),
    .busy          (busy),
    .done          (done)
  );

  always #5 prog_clk = ~prog_clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Chain model: bit CL-1 is the tail, new bits enter at bit 0
  logic [CL-1:0] chain      = '0;
  logic [CL-1:0] preset_val = '0;
  logic          preset_req = 1'b0;
  assign ccff_tail = chain[CL-1];
  always @(posedge prog_clk) begin
    if (preset_req)         chain <= preset_val;
    else if (ccff_shift_en) chain <= {chain[CL-2:0], ccff_head};
  end

  int acc_cyc[$];
  int start_cyc[$];
  always @(posedge prog_clk) begin
    cyc++;
    if (!pReset && bus.cfg_valid === 1'b1 && bus.cfg_ready === 1'b1) acc_cyc.push_back(cyc);
    if (!pReset && bus.cfg_start === 1'b1 && busy !== 1'b1) start_cyc.push_back(cyc);
  end

  bit         head_q[$];
  int         sh_cyc[$];
  logic [7:0] rb_q[$];
  int         rb_cyc[$];
  int         done_cyc[$];
  int         busy_rise[$];
  int         busy_fall[$];
  logic       busy_d = 1'b0;
  always @(negedge prog_clk) begin
    if (ccff_shift_en === 1'b1) begin head_q.push_back(ccff_head); sh_cyc.push_back(cyc); end
    if (bus.rb_valid === 1'b1) begin rb_q.push_back(bus.rb_data); rb_cyc.push_back(cyc); end
    if (done === 1'b1) done_cyc.push_back(cyc);
    if (busy === 1'b1 && busy_d !== 1'b1) busy_rise.push_back(cyc);
    if (busy !== 1'b1 && busy_d === 1'b1) busy_fall.push_back(cyc);
    busy_d = busy;
  end

  // Reference: head carries the byte stream LSB-first, truncated to CL bits;
  // readback is the pre-load chain in exit order, packed right-aligned.
  bit         exp_head[$];
  logic [7:0] exp_rb[$];
  function automatic void build_exp(input logic [CL-1:0] snap, input logic [7:0] b0, input logic [7:0] b1);
    logic [15:0] stream;
    logic [7:0]  r;
    stream = {b1, b0};
    exp_head.delete();
    exp_rb.delete();
    for (int i = 0; i < CL; i++) exp_head.push_back(stream[i]);
    for (int k = 0; k < NB; k++) begin
      r = '0;
      for (int j = 0; j < 8; j++) if (8*k + j < CL) r[j] = snap[CL-1-(8*k + j)];
      exp_rb.push_back(r);
    end
  endfunction

  int b_sh, b_acc, b_rb, b_done, b_start, b_rise, b_fall;

  task automatic preset(input logic [CL-1:0] v);
    @(negedge prog_clk);
    preset_val = v;
    preset_req = 1'b1;
    @(negedge prog_clk);
    preset_req = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] b0, input logic [7:0] b1, input int gap,
                         input bit hold, input bit disturb, output bit ok);
    logic [7:0] bytes [2];
    int t;
    bytes[0] = b0;
    bytes[1] = b1;
    ok = 1'b1;
    @(negedge prog_clk);
    build_exp(chain, b0, b1);
    b_sh = sh_cyc.size();  b_acc = acc_cyc.size(); b_rb = rb_q.size(); b_done = done_cyc.size();
    b_start = start_cyc.size(); b_rise = busy_rise.size(); b_fall = busy_fall.size();
    bus.cfg_start = 1'b1;
    @(negedge prog_clk);
    bus.cfg_start = 1'b0;
    for (int k = 0; k < NB; k++) begin
      if (gap > 0 && !(hold && k > 0)) begin
        t = 0;
        while (bus.cfg_ready !== 1'b1 && t < 200) begin @(negedge prog_clk); t++; end
        repeat (gap) @(negedge prog_clk);
      end
      bus.cfg_valid = 1'b1;
      bus.cfg_data  = bytes[k];
      t = 0;
      while (bus.cfg_ready !== 1'b1 && t < 200) begin @(negedge prog_clk); t++; end
      if (t >= 200) ok = 1'b0;
      @(negedge prog_clk);
      if (!hold || k == NB-1) begin bus.cfg_valid = 1'b0; bus.cfg_data = 8'h00; end
      if (disturb && k == 0) begin
        bus.cfg_start = 1'b1; bus.cfg_valid = 1'b1; bus.cfg_data = 8'hFF;
        repeat (3) @(negedge prog_clk);
        bus.cfg_start = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_data = 8'h00;
      end
    end
    t = 0;
    while (done_cyc.size() == b_done && t < 400) begin @(negedge prog_clk); t++; end
    if (t >= 400) ok = 1'b0;
    repeat (3) @(negedge prog_clk);
  endtask

  task automatic test_reset();
    pReset = 1'b1;
    repeat (3) @(negedge prog_clk);
    pReset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge prog_clk);
      checks++;
      if ({bus.cfg_ready, ccff_head, ccff_shift_en, bus.rb_valid, done, busy, bus.rb_data} !== 14'h0) begin
        failures++;
        $display("FAIL reset_idle cycle %0d got %b_%b_%b_%b_%b_%b_%h exp all 0", i, bus.cfg_ready,
                 ccff_head, ccff_shift_en, bus.rb_valid, done, busy, bus.rb_data);
      end
    end
  endtask

  task automatic test_load_basic();
    bit ok;
    logic [7:0] want [2];
    want[0] = 8'hFF; want[1] = 8'h0F;
    preset(12'hFFF);
    do_load(8'hA5, 8'h03, 0, 1'b0, 1'b0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL basic_timeout got timeout exp done"); end
    checks++;
    if (sh_cyc.size() - b_sh != CL) begin
      failures++; $display("FAIL basic_shift_count got %0d exp %0d", sh_cyc.size() - b_sh, CL);
    end
    for (int i = 0; i < CL; i++) begin
      checks++;
      if (head_q[b_sh+i] !== exp_head[i]) begin
        failures++; $display("FAIL basic_head[%0d] got %b exp %b", i, head_q[b_sh+i], exp_head[i]);
      end
    end
    for (int k = 0; k < NB; k++) begin
      checks++;
      if (rb_q[b_rb+k] !== want[k]) begin
        failures++; $display("FAIL basic_rb[%0d] got %h exp %h", k, rb_q[b_rb+k], want[k]);
      end
    end
    checks++;
    if (done_cyc.size() - b_done != 1) begin
      failures++; $display("FAIL basic_done_count got %0d exp 1", done_cyc.size() - b_done);
    end
    checks++;
    if (acc_cyc.size() - b_acc != NB) begin
      failures++; $display("FAIL basic_byte_count got %0d exp %0d", acc_cyc.size() - b_acc, NB);
    end
  endtask

  task automatic test_readback();
    bit ok;
    do_load(8'hA5, 8'hFF, 0, 1'b0, 1'b0, ok);
    checks++;
    if (!ok || rb_q[b_rb] !== 8'hA5 || rb_q[b_rb+1] !== 8'h03) begin
      failures++; $display("FAIL readback_prev got %h %h exp a5 03", rb_q[b_rb], rb_q[b_rb+1]);
    end
    do_load(8'h3C, 8'h00, 0, 1'b0, 1'b0, ok);
    checks++;
    if (!ok || rb_q[b_rb] !== 8'hA5 || rb_q[b_rb+1] !== 8'h0F) begin
      failures++; $display("FAIL readback_trunc got %h %h exp a5 0f", rb_q[b_rb], rb_q[b_rb+1]);
    end
  endtask

  task automatic test_gap();
    bit ok;
    do_load(8'hA5, 8'h03, 5, 1'b0, 1'b0, ok);
    checks++;
    if (!ok || sh_cyc.size() - b_sh != CL) begin
      failures++; $display("FAIL gap_shift_count got %0d exp %0d", sh_cyc.size() - b_sh, CL);
    end
    checks++;
    if (acc_cyc[b_acc+1] - acc_cyc[b_acc] != 14) begin
      failures++; $display("FAIL gap_accept_spacing got %0d exp 14", acc_cyc[b_acc+1] - acc_cyc[b_acc]);
    end
    for (int k = 0; k < NB; k++)
      for (int j = 0; j < 8 && 8*k + j < CL; j++) begin
        checks++;
        if (sh_cyc[b_sh+8*k+j] != acc_cyc[b_acc+k] + 1 + j) begin
          failures++; $display("FAIL gap_shift_cycle[%0d] got %0d exp %0d", 8*k + j,
                               sh_cyc[b_sh+8*k+j], acc_cyc[b_acc+k] + 1 + j);
        end
      end
    for (int i = 0; i < CL; i++) begin
      checks++;
      if (head_q[b_sh+i] !== exp_head[i]) begin
        failures++; $display("FAIL gap_head[%0d] got %b exp %b", i, head_q[b_sh+i], exp_head[i]);
      end
    end
    checks++;
    if (rb_q[b_rb] !== exp_rb[0] || rb_q[b_rb+1] !== exp_rb[1]) begin
      failures++; $display("FAIL gap_rb got %h %h exp %h %h", rb_q[b_rb], rb_q[b_rb+1], exp_rb[0], exp_rb[1]);
    end
  endtask

  task automatic test_ignore();
    bit ok;
    do_load(8'hA5, 8'h03, 0, 1'b0, 1'b1, ok);
    checks++;
    if (!ok || acc_cyc.size() - b_acc != NB || start_cyc.size() - b_start != 1) begin
      failures++; $display("FAIL ignore_counts got bytes=%0d starts=%0d exp %0d 1",
                           acc_cyc.size() - b_acc, start_cyc.size() - b_start, NB);
    end
    checks++;
    if (sh_cyc.size() - b_sh != CL || done_cyc.size() - b_done != 1) begin
      failures++; $display("FAIL ignore_shift_done got %0d %0d exp %0d 1",
                           sh_cyc.size() - b_sh, done_cyc.size() - b_done, CL);
    end
    for (int i = 0; i < CL; i++) begin
      checks++;
      if (head_q[b_sh+i] !== exp_head[i]) begin
        failures++; $display("FAIL ignore_head[%0d] got %b exp %b", i, head_q[b_sh+i], exp_head[i]);
      end
    end
    checks++;
    if (rb_q[b_rb] !== exp_rb[0] || rb_q[b_rb+1] !== exp_rb[1]) begin
      failures++; $display("FAIL ignore_rb got %h %h exp %h %h", rb_q[b_rb], rb_q[b_rb+1], exp_rb[0], exp_rb[1]);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [7:0] b0, b1;
    int last;
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    do_load(b0, b1, 0, 1'b1, 1'b0, ok);
    last = sh_cyc[sh_cyc.size()-1];
    checks++;
    if (!ok || acc_cyc[b_acc+1] - acc_cyc[b_acc] != 9) begin
      failures++; $display("FAIL b2b_throughput got %0d exp 9", acc_cyc[b_acc+1] - acc_cyc[b_acc]);
    end
    checks++;
    if (done_cyc[b_done] != last + 2) begin
      failures++; $display("FAIL b2b_done_latency got %0d exp %0d", done_cyc[b_done], last + 2);
    end
    checks++;
    if (rb_cyc[rb_cyc.size()-1] != last + 1) begin
      failures++; $display("FAIL b2b_rb_latency got %0d exp %0d", rb_cyc[rb_cyc.size()-1], last + 1);
    end
    checks++;
    if (busy_rise[b_rise] != start_cyc[b_start] || busy_fall[b_fall] != done_cyc[b_done] + 1) begin
      failures++; $display("FAIL b2b_busy got rise=%0d fall=%0d exp rise=%0d fall=%0d", busy_rise[b_rise],
                           busy_fall[b_fall], start_cyc[b_start], done_cyc[b_done] + 1);
    end
    for (int i = 0; i < CL; i++) begin
      checks++;
      if (head_q[b_sh+i] !== exp_head[i]) begin
        failures++; $display("FAIL b2b_head[%0d] got %b exp %b", i, head_q[b_sh+i], exp_head[i]);
      end
    end
  endtask

  task automatic test_reset_midload();
    bit ok;
    int n, t, r0, d0;
    preset(12'h5A3);
    @(negedge prog_clk);
    r0 = rb_q.size();
    d0 = done_cyc.size();
    bus.cfg_start = 1'b1;
    @(negedge prog_clk);
    bus.cfg_start = 1'b0;
    bus.cfg_valid = 1'b1;
    bus.cfg_data  = 8'hC3;
    @(negedge prog_clk);
    bus.cfg_valid = 1'b0;
    n = 0; t = 0;
    while (n < 5 && t < 100) begin
      @(negedge prog_clk);
      t++;
      if (ccff_shift_en === 1'b1) n++;
    end
    checks++;
    if (n != 5) begin failures++; $display("FAIL midreset_shifts got %0d exp 5", n); end
    pReset = 1'b1;
    @(negedge prog_clk);
    pReset = 1'b0;
    checks++;
    if ({bus.cfg_ready, ccff_head, ccff_shift_en, bus.rb_valid, done, busy, bus.rb_data} !== 14'h0) begin
      failures++; $display("FAIL midreset_outputs got %b_%b_%b_%b_%b_%b_%h exp all 0", bus.cfg_ready,
                           ccff_head, ccff_shift_en, bus.rb_valid, done, busy, bus.rb_data);
    end
    repeat (20) @(negedge prog_clk);
    checks++;
    if (rb_q.size() != r0 || done_cyc.size() != d0 || busy !== 1'b0) begin
      failures++; $display("FAIL midreset_quiet got rb=%0d done=%0d busy=%b exp 0 0 0",
                           rb_q.size() - r0, done_cyc.size() - d0, busy);
    end
    do_load(8'hA5, 8'h03, 0, 1'b0, 1'b0, ok);
    for (int i = 0; i < CL; i++) begin
      checks++;
      if (head_q[b_sh+i] !== exp_head[i]) begin
        failures++; $display("FAIL midreset_head[%0d] got %b exp %b", i, head_q[b_sh+i], exp_head[i]);
      end
    end
    checks++;
    if (!ok || rb_q[b_rb] !== exp_rb[0] || rb_q[b_rb+1] !== exp_rb[1]) begin
      failures++; $display("FAIL midreset_rb got %h %h exp %h %h", rb_q[b_rb], rb_q[b_rb+1], exp_rb[0], exp_rb[1]);
    end
  endtask

  task automatic test_random();
    bit ok;
    int bad;
    for (int it = 0; it < 8; it++) begin
      preset(CL'($urandom));
      do_load(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), 1'b0, ok);
      bad = 0;
      for (int i = 0; i < CL; i++) if (head_q[b_sh+i] !== exp_head[i]) bad++;
      checks++;
      if (!ok || bad != 0 || sh_cyc.size() - b_sh != CL) begin
        failures++; $display("FAIL rand%0d_head got %0d bad bits, %0d shifts exp 0 bad, %0d shifts",
                             it, bad, sh_cyc.size() - b_sh, CL);
      end
      checks++;
      if (rb_q[b_rb] !== exp_rb[0] || rb_q[b_rb+1] !== exp_rb[1] || done_cyc.size() - b_done != 1) begin
        failures++; $display("FAIL rand%0d_rb got %h %h exp %h %h", it, rb_q[b_rb], rb_q[b_rb+1], exp_rb[0], exp_rb[1]);
      end
    end
  endtask

  initial begin
    bus.cfg_start = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_data  = 8'h00;
    test_reset();
    test_load_basic();
    test_readback();
    test_gap();
    test_ignore();
    test_back_to_back();
    test_reset_midload();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
